// File: rtl/pet_needs_engine.sv
`default_nettype none
// ============================================================================
// Module   : pet_needs_engine
// Brief    : Need/health meters for the virtual pet. Needs decay on a
//            seconds timer and are raised by care pulses. Critical needs
//            drain health, and zero health latches death. A test mode
//            freezes time and allows direct edits of every meter.
// Revision : 1.0 - initial release
// ============================================================================
module pet_needs_engine #(
    parameter int NUM_NEEDS   = 4,
    parameter int LEVEL_W     = 3,
    parameter int LEVEL_MAX   = 5,
    parameter int TICK_CYCLES = 50000000,
    parameter int DECAY_SEC   = 30,
    parameter int CRIT_LEVEL  = 2,
    parameter int CRIT_SEC    = 20,
    parameter int MOOD_MID    = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_NEEDS-1:0]             care_pulse,
    input  logic                             heal_pulse,
    input  logic                             test_toggle,
    input  logic                             test_sel,
    input  logic                             test_inc,
    input  logic                             test_dec,
    output logic [NUM_NEEDS*LEVEL_W-1:0]     levels,
    output logic [LEVEL_W-1:0]               health,
    output logic [1:0]                       mood,
    output logic                             dead,
    output logic                             test_mode,
    output logic [$clog2(NUM_NEEDS+1)-1:0]   test_ch,
    output logic                             sec_tick
);

    localparam int c_ch_w   = $clog2(NUM_NEEDS + 1);
    localparam int c_tick_w = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int c_dec_w  = $clog2(DECAY_SEC + 1);
    localparam int c_crit_w = $clog2(CRIT_SEC + 1);

    localparam logic [c_tick_w-1:0] c_tick_last  = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [c_dec_w-1:0]  c_decay_last = c_dec_w'(DECAY_SEC - 1);
    localparam logic [c_crit_w-1:0] c_crit_last  = c_crit_w'(CRIT_SEC - 1);
    localparam logic [LEVEL_W-1:0]  c_lvl_max    = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0]  c_crit_lvl   = LEVEL_W'(CRIT_LEVEL);
    localparam logic [LEVEL_W-1:0]  c_mood_mid   = LEVEL_W'(MOOD_MID);
    localparam logic [c_ch_w-1:0]   c_health_ch  = c_ch_w'(NUM_NEEDS);

    logic [c_tick_w-1:0] r_tick_cnt;
    logic                r_sec_tick;
    logic [LEVEL_W-1:0]  r_level [NUM_NEEDS];
    logic [c_dec_w-1:0]  r_dtmr  [NUM_NEEDS];
    logic [c_crit_w-1:0] r_ctmr;
    logic [LEVEL_W-1:0]  r_health;
    logic [1:0]          r_mood;
    logic                r_dead;
    logic                r_test_mode;
    logic [c_ch_w-1:0]   r_test_ch;

    logic [LEVEL_W-1:0]  w_level_nxt [NUM_NEEDS];
    logic [c_dec_w-1:0]  w_dtmr_nxt  [NUM_NEEDS];
    logic [NUM_NEEDS-1:0] w_decay;
    logic [c_crit_w-1:0] w_ctmr_nxt;
    logic [LEVEL_W-1:0]  w_health_nxt;
    logic                w_dead_nxt;
    logic                w_test_mode_nxt;
    logic [c_ch_w-1:0]   w_test_ch_nxt;
    logic                w_any_crit;
    logic                w_active;
    logic                w_edit;
    logic                w_penalty;
    logic                w_low;
    logic                w_mid;
    logic [1:0]          w_mood_nxt;

    function automatic logic [LEVEL_W-1:0] f_sat_inc(input logic [LEVEL_W-1:0] v);
        return (v >= c_lvl_max) ? c_lvl_max : v + 1'b1;
    endfunction

    function automatic logic [LEVEL_W-1:0] f_sat_dec(input logic [LEVEL_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Free-running seconds prescaler; keeps running in test mode and after death.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_sec_tick <= 1'b0;
        end else if (r_tick_cnt == c_tick_last) begin
            r_tick_cnt <= '0;
            r_sec_tick <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            r_sec_tick <= 1'b0;
        end
    end

    // Next-state for needs, health, timers, test mode and death.
    always_comb begin
        w_level_nxt     = r_level;
        w_dtmr_nxt      = r_dtmr;
        w_decay         = '0;
        w_ctmr_nxt      = r_ctmr;
        w_health_nxt    = r_health;
        w_dead_nxt      = r_dead;
        w_test_mode_nxt = r_test_mode;
        w_test_ch_nxt   = r_test_ch;
        w_penalty       = 1'b0;
        w_any_crit      = 1'b0;
        w_active        = !r_dead && !r_test_mode;
        w_edit          = !r_dead && r_test_mode && (test_inc ^ test_dec);

        for (int i = 0; i < NUM_NEEDS; i++) begin
            if (r_level[i] < c_crit_lvl) w_any_crit = 1'b1;
        end

        for (int i = 0; i < NUM_NEEDS; i++) begin
            w_decay[i] = r_sec_tick && (r_dtmr[i] == c_decay_last);
            if (w_active) begin
                if (care_pulse[i]) begin
                    // Care cancels a coincident decay; either way the timer restarts.
                    w_dtmr_nxt[i] = '0;
                    if (!w_decay[i]) w_level_nxt[i] = f_sat_inc(r_level[i]);
                end else if (r_sec_tick) begin
                    if (w_decay[i]) begin
                        w_dtmr_nxt[i]  = '0;
                        w_level_nxt[i] = f_sat_dec(r_level[i]);
                    end else begin
                        w_dtmr_nxt[i] = r_dtmr[i] + 1'b1;
                    end
                end
            end else if (w_edit && (r_test_ch == c_ch_w'(i))) begin
                w_level_nxt[i] = test_inc ? f_sat_inc(r_level[i]) : f_sat_dec(r_level[i]);
            end
        end

        if (w_active) begin
            if (!w_any_crit) begin
                w_ctmr_nxt = '0;
            end else if (r_sec_tick) begin
                if (r_ctmr == c_crit_last) begin
                    w_penalty  = 1'b1;
                    w_ctmr_nxt = '0;
                end else begin
                    w_ctmr_nxt = r_ctmr + 1'b1;
                end
            end
            if (heal_pulse && !w_penalty) w_health_nxt = f_sat_inc(r_health);
            else if (w_penalty && !heal_pulse) w_health_nxt = f_sat_dec(r_health);
        end else if (w_edit && (r_test_ch == c_health_ch)) begin
            w_health_nxt = test_inc ? f_sat_inc(r_health) : f_sat_dec(r_health);
        end

        if (!r_dead && r_test_mode && test_sel) begin
            w_test_ch_nxt = (r_test_ch == c_health_ch) ? '0 : r_test_ch + 1'b1;
        end
        if (!r_dead && test_toggle) begin
            w_test_mode_nxt = !r_test_mode;
            if (!r_test_mode) w_test_ch_nxt = '0;
        end

        // Reaching zero health kills the pet on the same update.
        if (!r_dead && (w_health_nxt == '0)) begin
            w_dead_nxt      = 1'b1;
            w_test_mode_nxt = 1'b0;
            for (int i = 0; i < NUM_NEEDS; i++) w_level_nxt[i] = '0;
        end
    end

    // Mood from the currently held meters, so it trails level changes by one cycle.
    always_comb begin
        w_low = (r_health < c_mood_mid);
        w_mid = (r_health == c_mood_mid);
        for (int i = 0; i < NUM_NEEDS; i++) begin
            w_low = w_low | (r_level[i] < c_mood_mid);
            w_mid = w_mid | (r_level[i] == c_mood_mid);
        end
        if (r_dead)     w_mood_nxt = 2'd3;
        else if (w_low) w_mood_nxt = 2'd2;
        else if (w_mid) w_mood_nxt = 2'd1;
        else            w_mood_nxt = 2'd0;
    end

    // State registers for meters, timers, mode and mood.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEEDS; i++) begin
                r_level[i] <= c_lvl_max;
                r_dtmr[i]  <= '0;
            end
            r_ctmr      <= '0;
            r_health    <= c_lvl_max;
            r_mood      <= 2'd0;
            r_dead      <= 1'b0;
            r_test_mode <= 1'b0;
            r_test_ch   <= '0;
        end else begin
            r_level     <= w_level_nxt;
            r_dtmr      <= w_dtmr_nxt;
            r_ctmr      <= w_ctmr_nxt;
            r_health    <= w_health_nxt;
            r_mood      <= w_mood_nxt;
            r_dead      <= w_dead_nxt;
            r_test_mode <= w_test_mode_nxt;
            r_test_ch   <= w_test_ch_nxt;
        end
    end

    generate
        for (genvar g = 0; g < NUM_NEEDS; g++) begin : g_pack
            assign levels[g*LEVEL_W +: LEVEL_W] = r_level[g];
        end
    endgenerate

    assign health    = r_health;
    assign mood      = r_mood;
    assign dead      = r_dead;
    assign test_mode = r_test_mode;
    assign test_ch   = r_test_ch;
    assign sec_tick  = r_sec_tick;

endmodule
`default_nettype wire

// File: tb/tb_pet_needs_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pet_needs_engine
// Brief    : Self-checking bench for pet_needs_engine: a vector table for
//            test-mode editing, hand sequences for decay, penalty, death and
//            reset timing, and random stimulus against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pet_needs_engine;

    localparam int NN    = 4;
    localparam int LW    = 3;
    localparam int LMAX  = 5;
    localparam int TICKS = 10;
    localparam int DSEC  = 3;
    localparam int CLVL  = 2;
    localparam int CSEC  = 2;
    localparam int MID   = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NN-1:0]  care_pulse = '0;
    logic           heal_pulse = 1'b0;
    logic           test_toggle = 1'b0;
    logic           test_sel = 1'b0;
    logic           test_inc = 1'b0;
    logic           test_dec = 1'b0;
    logic [NN*LW-1:0] levels;
    logic [LW-1:0]  health;
    logic [1:0]     mood;
    logic           dead;
    logic           test_mode;
    logic [2:0]     test_ch;
    logic           sec_tick;

    pet_needs_engine #(
        .NUM_NEEDS(NN), .LEVEL_W(LW), .LEVEL_MAX(LMAX), .TICK_CYCLES(TICKS),
        .DECAY_SEC(DSEC), .CRIT_LEVEL(CLVL), .CRIT_SEC(CSEC), .MOOD_MID(MID)
    ) dut (
        .clk(clk), .rst(rst), .care_pulse(care_pulse), .heal_pulse(heal_pulse),
        .test_toggle(test_toggle), .test_sel(test_sel), .test_inc(test_inc),
        .test_dec(test_dec), .levels(levels), .health(health), .mood(mood),
        .dead(dead), .test_mode(test_mode), .test_ch(test_ch), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model state, plain integers.
    int m_lvl [NN];
    int m_dt  [NN];
    int m_h, m_ct, m_tick, m_sec, m_mood, m_dead, m_tm, m_ch;

    typedef struct {
        logic [NN-1:0] care;
        logic          heal, tog, sel, inc, dec;
        logic [11:0]   lv;
        logic [2:0]    h;
        logic [1:0]    md;
        logic          tm;
        logic [2:0]    ch;
    } vec_t;

    vec_t tbl [21];

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > LMAX) ? LMAX : v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            m_lvl[i] = LMAX;
            m_dt[i]  = 0;
        end
        m_h = LMAX; m_ct = 0; m_tick = 0; m_sec = 0;
        m_mood = 0; m_dead = 0; m_tm = 0; m_ch = 0;
    endtask

    // One clock edge of the pet rules, applied to the inputs seen at that edge.
    task automatic model_step();
        int nl [NN];
        int nd [NN];
        int nh, nct, nch, ntm, ndead, mn, delta;
        bit crit, pen;
        nl = m_lvl; nd = m_dt; nh = m_h; nct = m_ct;
        nch = m_ch; ntm = m_tm; ndead = m_dead;

        mn = m_h;
        crit = 0;
        for (int i = 0; i < NN; i++) begin
            if (m_lvl[i] < mn) mn = m_lvl[i];
            if (m_lvl[i] < CLVL) crit = 1;
        end

        if (!m_dead && !m_tm) begin
            for (int i = 0; i < NN; i++) begin
                if (care_pulse[i]) begin
                    nd[i] = 0;
                    if (!(m_sec == 1 && m_dt[i] + 1 == DSEC)) nl[i] = clamp(m_lvl[i] + 1);
                end else if (m_sec == 1) begin
                    nd[i] = m_dt[i] + 1;
                    if (nd[i] == DSEC) begin
                        nd[i] = 0;
                        nl[i] = clamp(m_lvl[i] - 1);
                    end
                end
            end
            pen = crit && (m_sec == 1) && (m_ct + 1 == CSEC);
            if (!crit) nct = 0;
            else if (m_sec == 1) nct = pen ? 0 : m_ct + 1;
            nh = clamp(m_h + int'(heal_pulse) - int'(pen));
        end else if (!m_dead) begin
            delta = int'(test_inc) - int'(test_dec);
            if (m_ch < NN) nl[m_ch] = clamp(m_lvl[m_ch] + delta);
            else nh = clamp(m_h + delta);
            if (test_sel) nch = (m_ch + 1) % (NN + 1);
        end

        if (!m_dead && test_toggle) begin
            ntm = m_tm ? 0 : 1;
            if (!m_tm) nch = 0;
        end

        if (!m_dead && nh == 0) begin
            ndead = 1;
            ntm = 0;
            for (int i = 0; i < NN; i++) nl[i] = 0;
        end

        m_mood = m_dead ? 3 : ((mn < MID) ? 2 : ((mn == MID) ? 1 : 0));
        m_sec  = (m_tick == TICKS - 1) ? 1 : 0;
        m_tick = (m_tick + 1) % TICKS;
        m_lvl = nl; m_dt = nd; m_h = nh; m_ct = nct;
        m_ch = nch; m_tm = ntm; m_dead = ndead;
    endtask

    task automatic check_model();
        logic [22:0] act, exp;
        logic [11:0] el;
        for (int i = 0; i < NN; i++) el[i*LW +: LW] = LW'(m_lvl[i]);
        act = {levels, health, mood, dead, test_mode, test_ch, sec_tick};
        exp = {el, 3'(m_h), 2'(m_mood), 1'(m_dead), 1'(m_tm), 3'(m_ch), 1'(m_sec)};
        chk("model", int'(act), int'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step();
            edge_n++;
        end
        #1;
        check_model();
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic clear_inputs();
        care_pulse = '0; heal_pulse = 1'b0; test_toggle = 1'b0;
        test_sel = 1'b0; test_inc = 1'b0; test_dec = 1'b0;
    endtask

    // Asynchronous reset taken mid-cycle; outputs must be at reset values at once.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_levels", int'(levels), 'o5555);
        chk("rst_health", int'(health), 5);
        chk("rst_mood", int'(mood), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_test_mode", int'(test_mode), 0);
        chk("rst_test_ch", int'(test_ch), 0);
        chk("rst_sec_tick", int'(sec_tick), 0);
        repeat (2) tick();
        rst = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        int dn;
        int dead_cycles;

        //          care     heal  tog   sel   inc   dec   levels    h     md    tm    ch
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'o5555, 3'd5, 2'd0, 1'b0, 3'd0};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o5555, 3'd5, 2'd0, 1'b1, 3'd0};
        tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o5554, 3'd5, 2'd0, 1'b1, 3'd0};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o5553, 3'd5, 2'd0, 1'b1, 3'd0};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o5553, 3'd5, 2'd1, 1'b1, 3'd1};
        tbl[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o5553, 3'd5, 2'd1, 1'b1, 3'd1};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'o5553, 3'd5, 2'd1, 1'b1, 3'd1};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o5553, 3'd5, 2'd1, 1'b1, 3'd2};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o5553, 3'd5, 2'd1, 1'b1, 3'd3};
        tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o5553, 3'd5, 2'd1, 1'b1, 3'd4};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o5553, 3'd4, 2'd1, 1'b1, 3'd4};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o5553, 3'd3, 2'd1, 1'b1, 3'd4};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o5553, 3'd3, 2'd1, 1'b1, 3'd0};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'o5552, 3'd3, 2'd1, 1'b1, 3'd0};
        tbl[14] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'o5552, 3'd3, 2'd2, 1'b1, 3'd0};
        tbl[15] = '{4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'o5552, 3'd3, 2'd2, 1'b1, 3'd0};
        tbl[16] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o5553, 3'd3, 2'd2, 1'b1, 3'd0};
        tbl[17] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o5554, 3'd3, 2'd1, 1'b1, 3'd0};
        tbl[18] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o5555, 3'd3, 2'd1, 1'b1, 3'd0};
        tbl[19] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o5555, 3'd3, 2'd1, 1'b1, 3'd0};
        tbl[20] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o5555, 3'd3, 2'd1, 1'b0, 3'd0};

        #2;
        // Decay timing, care racing decay, health penalties, death.
        async_reset();
        run_to(10); chk("sec_tick_on_wrap", int'(sec_tick), 1);
        run_to(11); chk("sec_tick_one_cycle", int'(sec_tick), 0);
        run_to(30); chk("no_decay_yet", int'(levels), 'o5555);
        run_to(31); chk("first_decay", int'(levels), 'o4444);
        run_to(32); chk("mood_happy", int'(mood), 0);
        run_to(61); chk("second_decay", int'(levels), 'o3333);
        run_to(62); chk("mood_neutral", int'(mood), 1);
        run_to(90); care_pulse = 4'b0001; tick(); care_pulse = '0;
        chk("care_vs_decay", int'(levels), 'o2223);
        run_to(121); chk("levels_critical", int'(levels), 'o1112);
        run_to(140); chk("health_before_penalty", int'(health), 5);
        run_to(141); chk("first_penalty", int'(health), 4);
        run_to(160); heal_pulse = 1'b1; tick(); heal_pulse = 1'b0;
        chk("heal_vs_penalty", int'(health), 4);
        run_to(181); chk("third_penalty", int'(health), 3);
        run_to(240); chk("health_last", int'(health), 1);
        chk("alive_before", int'(dead), 0);
        tick();
        chk("dead_latched", int'(dead), 1);
        chk("dead_health", int'(health), 0);
        chk("dead_levels", int'(levels), 0);
        tick(); chk("mood_dead", int'(mood), 3);
        care_pulse = '1; heal_pulse = 1'b1; test_toggle = 1'b1;
        repeat (3) tick();
        clear_inputs();
        chk("dead_ignores_care", int'(levels), 0);
        chk("dead_ignores_heal", int'(health), 0);
        chk("dead_ignores_toggle", int'(test_mode), 0);
        chk("dead_stays", int'(dead), 1);

        // Test mode freezes decay and resumes the held timers.
        async_reset();
        run_to(24); test_toggle = 1'b1; tick(); test_toggle = 1'b0;
        chk("enter_test", int'(test_mode), 1);
        run_to(129); chk("frozen_decay", int'(levels), 'o5555);
        test_toggle = 1'b1; tick(); test_toggle = 1'b0;
        chk("leave_test", int'(test_mode), 0);
        tick(); chk("resume_decay", int'(levels), 'o4444);
        test_toggle = 1'b1; tick(); test_toggle = 1'b0;
        test_sel = 1'b1; repeat (4) tick(); test_sel = 1'b0;
        chk("sel_health_ch", int'(test_ch), 4);
        test_dec = 1'b1; repeat (4) tick();
        chk("edit_health", int'(health), 1);
        chk("edit_alive", int'(dead), 0);
        tick(); test_dec = 1'b0;
        chk("edit_kill", int'(dead), 1);
        chk("edit_kill_tm", int'(test_mode), 0);
        chk("edit_kill_levels", int'(levels), 0);

        // Reset mid-decay and mid-test; prescaler restarts from zero.
        async_reset();
        run_to(35); chk("pre_rst_decay", int'(levels), 'o4444);
        test_toggle = 1'b1; tick(); test_toggle = 1'b0;
        test_dec = 1'b1; tick(); test_dec = 1'b0;
        chk("pre_rst_edit", int'(levels), 'o4443);
        async_reset();
        run_to(9);  chk("restart_no_tick", int'(sec_tick), 0);
        run_to(10); chk("restart_tick", int'(sec_tick), 1);

        // Vector table: test-mode editing and ignored pulses.
        async_reset();
        run_to(3);
        for (int r = 0; r < 21; r++) begin
            care_pulse = tbl[r].care; heal_pulse = tbl[r].heal;
            test_toggle = tbl[r].tog; test_sel = tbl[r].sel;
            test_inc = tbl[r].inc; test_dec = tbl[r].dec;
            tick();
            clear_inputs();
            chk($sformatf("tbl%0d_levels", r), int'(levels), int'(tbl[r].lv));
            chk($sformatf("tbl%0d_health", r), int'(health), int'(tbl[r].h));
            chk($sformatf("tbl%0d_mood", r), int'(mood), int'(tbl[r].md));
            chk($sformatf("tbl%0d_tm", r), int'(test_mode), int'(tbl[r].tm));
            chk($sformatf("tbl%0d_ch", r), int'(test_ch), int'(tbl[r].ch));
        end

        // Random stimulus against the model, with care pressure varied by epoch.
        async_reset();
        dead_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            dn = (i / 1000 == 1) ? 64 : ((i / 1000 == 2) ? 256 : 16);
            for (int b = 0; b < NN; b++) care_pulse[b] = ($urandom_range(dn - 1, 0) == 0);
            heal_pulse  = ($urandom_range(15, 0) == 0);
            test_toggle = ($urandom_range(39, 0) == 0);
            test_sel    = ($urandom_range(5, 0) == 0);
            test_inc    = ($urandom_range(3, 0) == 0);
            test_dec    = ($urandom_range(3, 0) == 0);
            tick();
            if (m_dead != 0) dead_cycles++;
            else dead_cycles = 0;
            if (dead_cycles > 20) begin
                clear_inputs();
                async_reset();
                dead_cycles = 0;
            end
        end
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
